// File: rtl/nios_with_no_onchip_sdram_cpu_oci_dct_packer.sv
// Trace atom packer: collects 2-bit atoms into a 30-bit buffer and hands
// full or flushed buffers to a single-entry frame slot with valid/ready.
module nios_with_no_onchip_sdram_cpu_oci_dct_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trc_on,
  input  logic        atm_valid,
  input  logic [1:0]  atm_data,
  output logic        atm_ready,
  input  logic        flush,
  input  logic        clr_ovf,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [29:0] frame_data,
  output logic [3:0]  frame_count,
  output logic        overflow
);

  localparam int unsigned ATOM_W = 2;
  localparam int unsigned DEPTH  = 15;
  localparam int unsigned BUF_W  = ATOM_W * DEPTH;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

  slot_t              state;
  slot_t              state_nxt;
  logic               flush_pend;
  logic               slot_free;
  logic               flush_req;
  logic               buf_full;
  logic               xfer;
  logic               accept;
  logic               consume;
  logic               ovf_set;
  logic [BUF_W-1:0]   buf_ins;

  assign frame_valid = (state == SLOT_FULL);
  assign slot_free   = ~frame_valid | frame_ready;
  assign consume     = frame_valid & frame_ready;
  assign flush_req   = flush | flush_pend;
  assign buf_full    = (dct_count == CNT_W'(DEPTH));
  assign xfer        = slot_free & (buf_full | (flush_req & (dct_count != '0)));
  assign atm_ready   = trc_on & ~buf_full & ~xfer;
  assign accept      = atm_valid & atm_ready;
  assign ovf_set     = atm_valid & trc_on & ~atm_ready;

  // Buffer with the offered atom dropped into the slot selected by dct_count
  always_comb begin
    buf_ins = dct_buffer;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (dct_count == CNT_W'(i)) begin
        buf_ins[ATOM_W*i +: ATOM_W] = atm_data;
      end
    end
  end

  // Frame slot state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame slot next state: a new frame may enter the same cycle the old one leaves
  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_EMPTY: if (xfer) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (consume && !xfer) state_nxt = SLOT_EMPTY;
    endcase
  end

  // Packing buffer, frame payload, pending flush and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer  <= '0;
      dct_count   <= '0;
      frame_data  <= '0;
      frame_count <= '0;
      flush_pend  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (xfer) begin
        frame_data  <= dct_buffer;
        frame_count <= dct_count;
        dct_buffer  <= '0;
        dct_count   <= '0;
        flush_pend  <= 1'b0;
      end else begin
        if (accept) begin
          dct_buffer <= buf_ins;
          dct_count  <= dct_count + CNT_W'(1);
        end
        // An empty buffer has nothing to flush, so the request is dropped
        if (flush) begin
          flush_pend <= (dct_count != '0);
        end
      end
      overflow <= ovf_set | (overflow & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_nios_with_no_onchip_sdram_cpu_oci_dct_packer.sv
// Self-checking bench for the trace atom packer: directed vector table plus
// hand-written multi-cycle sequences (full frames, backpressure, reset, trace off).
module tb_nios_with_no_onchip_sdram_cpu_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        trc_on;
  logic        atm_valid;
  logic [1:0]  atm_data;
  logic        atm_ready;
  logic        flush;
  logic        clr_ovf;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  nios_with_no_onchip_sdram_cpu_oci_dct_packer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .trc_on      (trc_on),
    .atm_valid   (atm_valid),
    .atm_data    (atm_data),
    .atm_ready   (atm_ready),
    .flush       (flush),
    .clr_ovf     (clr_ovf),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        trc;
    logic        av;
    logic [1:0]  ad;
    logic        fl;
    logic        fr;
    logic        co;
    logic        e_rdy;
    logic [3:0]  e_cnt;
    logic [29:0] e_buf;
    logic        e_fv;
    logic [3:0]  e_fc;
    logic [29:0] e_fd;
    logic        e_ovf;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vec [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic t, input logic av, input logic [1:0] ad,
                       input logic fl, input logic fr, input logic co);
    @(negedge clk);
    trc_on      = t;
    atm_valid   = av;
    atm_data    = ad;
    flush       = fl;
    frame_ready = fr;
    clr_ovf     = co;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    // trc av ad fl fr co | rdy cnt buf fv fc fd ovf
    vec[0]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 30'h1,  1'b0, 4'd0, 30'h0,  1'b0};
    vec[1]  = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 30'h9,  1'b0, 4'd0, 30'h0,  1'b0};
    vec[2]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 30'h39, 1'b0, 4'd0, 30'h0,  1'b0};
    vec[3]  = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0,  1'b1, 4'd3, 30'h39, 1'b0};
    vec[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 30'h0,  1'b0, 4'd0, 30'h0,  1'b0};
    vec[5]  = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 30'h0,  1'b0, 4'd0, 30'h0,  1'b0};
    vec[6]  = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 30'h2,  1'b0, 4'd0, 30'h0,  1'b0};
    vec[7]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 30'h2,  1'b0, 4'd0, 30'h0,  1'b0};
    vec[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 30'h2,  1'b0, 4'd0, 30'h0,  1'b0};
    vec[9]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0,  1'b1, 4'd1, 30'h2,  1'b0};
    vec[10] = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 30'h1,  1'b1, 4'd1, 30'h2,  1'b0};
    vec[11] = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 30'h9,  1'b1, 4'd1, 30'h2,  1'b0};
    vec[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 30'h9,  1'b1, 4'd1, 30'h2,  1'b0};
    vec[13] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0,  1'b1, 4'd2, 30'h9,  1'b1};
    vec[14] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, 4'd0, 30'h0,  1'b0};

    reset_n = 1'b0; trc_on = 1'b0; atm_valid = 1'b0; atm_data = 2'b00;
    flush = 1'b0; clr_ovf = 1'b0; frame_ready = 1'b0;
    tick(); tick();
    chk("rst_cnt", 32'(dct_count), 32'd0);
    chk("rst_buf", 32'(dct_buffer), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_fd", 32'(frame_data), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      apply(vec[i].trc, vec[i].av, vec[i].ad, vec[i].fl, vec[i].fr, vec[i].co);
      chk($sformatf("v%0d_rdy", i), 32'(atm_ready), 32'(vec[i].e_rdy));
      tick();
      chk($sformatf("v%0d_cnt", i), 32'(dct_count), 32'(vec[i].e_cnt));
      chk($sformatf("v%0d_buf", i), 32'(dct_buffer), 32'(vec[i].e_buf));
      chk($sformatf("v%0d_fv", i), 32'(frame_valid), 32'(vec[i].e_fv));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vec[i].e_ovf));
      if (vec[i].e_fv) begin
        chk($sformatf("v%0d_fc", i), 32'(frame_count), 32'(vec[i].e_fc));
        chk($sformatf("v%0d_fd", i), 32'(frame_data), 32'(vec[i].e_fd));
      end
      if (i == 5) chk("v5_flush_pend", 32'(dut.flush_pend), 32'd0);
    end

    // 15 atoms i%4 form a full frame
    for (int i = 0; i < 15; i++) begin
      apply(1'b1, 1'b1, 2'(i % 4), 1'b0, 1'b1, 1'b0);
      chk($sformatf("full_rdy%0d", i), 32'(atm_ready), 32'd1);
      tick();
    end
    chk("full_cnt15", 32'(dct_count), 32'd15);
    chk("full_buf", 32'(dct_buffer), 32'h24E4E4E4);
    chk("full_fv_pre", 32'(frame_valid), 32'd0);
    apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("full_rdy_xfer", 32'(atm_ready), 32'd0);
    tick();
    chk("full_fv", 32'(frame_valid), 32'd1);
    chk("full_fc", 32'(frame_count), 32'd15);
    chk("full_fd", 32'(frame_data), 32'h24E4E4E4);
    chk("full_cnt0", 32'(dct_count), 32'd0);
    apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    chk("full_consumed", 32'(frame_valid), 32'd0);

    // Backpressure: 30 atoms fill slot and buffer, the 31st overflows
    apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    k = 0;
    for (int c = 0; c < 100 && k < 30; c++) begin
      @(negedge clk);
      if (atm_ready) begin
        atm_valid = 1'b1;
        atm_data  = 2'(k % 4);
        k++;
      end else begin
        atm_valid = 1'b0;
      end
      @(posedge clk);
    end
    #1;
    chk("bp_fill_budget", 32'(k), 32'd30);
    chk("bp_cnt", 32'(dct_count), 32'd15);
    chk("bp_buf", 32'(dct_buffer), 32'h13939393);
    chk("bp_fv", 32'(frame_valid), 32'd1);
    chk("bp_fc", 32'(frame_count), 32'd15);
    chk("bp_fd_held", 32'(frame_data), 32'h24E4E4E4);
    chk("bp_ovf_pre", 32'(overflow), 32'd0);
    apply(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("bp_rdy_full", 32'(atm_ready), 32'd0);
    tick();
    chk("bp_ovf31", 32'(overflow), 32'd1);
    chk("bp_cnt_hold", 32'(dct_count), 32'd15);
    chk("bp_buf_hold", 32'(dct_buffer), 32'h13939393);
    apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("bp_rdy_xfer", 32'(atm_ready), 32'd0);
    tick();
    chk("bp_fv2", 32'(frame_valid), 32'd1);
    chk("bp_fc2", 32'(frame_count), 32'd15);
    chk("bp_fd2", 32'(frame_data), 32'h13939393);
    chk("bp_cnt0", 32'(dct_count), 32'd0);
    chk("bp_ovf_sticky", 32'(overflow), 32'd1);
    apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bp_ovf_clr", 32'(overflow), 32'd0);
    chk("bp_fv2_held", 32'(frame_valid), 32'd1);

    // Pending flush with slot full, then set and clear of overflow together
    apply(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("sc_rdy", 32'(atm_ready), 32'd1);
    tick();
    chk("sc_cnt1", 32'(dct_count), 32'd1);
    apply(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
    chk("sc_rdy_xfer", 32'(atm_ready), 32'd0);
    tick();
    chk("sc_ovf_set_wins", 32'(overflow), 32'd1);
    chk("sc_fc", 32'(frame_count), 32'd1);
    chk("sc_fd", 32'(frame_data), 32'h2);
    chk("sc_cnt0", 32'(dct_count), 32'd0);
    apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    tick();
    chk("sc_ovf_clr", 32'(overflow), 32'd0);
    chk("sc_fv0", 32'(frame_valid), 32'd0);

    // Trace off: offered atoms are ignored and never flag overflow
    for (int i = 1; i <= 3; i++) begin
      apply(1'b1, 1'b1, 2'(i), 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("off_cnt_pre", 32'(dct_count), 32'd3);
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
      chk($sformatf("off_rdy%0d", i), 32'(atm_ready), 32'd0);
      tick();
    end
    chk("off_cnt", 32'(dct_count), 32'd3);
    chk("off_buf", 32'(dct_buffer), 32'h39);
    chk("off_ovf", 32'(overflow), 32'd0);

    // Asynchronous reset with a held frame and 7 atoms buffered
    apply(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ar_fv", 32'(frame_valid), 32'd1);
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("ar_cnt7", 32'(dct_count), 32'd7);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_cnt", 32'(dct_count), 32'd0);
    chk("ar_buf", 32'(dct_buffer), 32'd0);
    chk("ar_fv0", 32'(frame_valid), 32'd0);
    chk("ar_fd", 32'(frame_data), 32'd0);
    chk("ar_fc", 32'(frame_count), 32'd0);
    chk("ar_ovf", 32'(overflow), 32'd0);
    chk("ar_pend", 32'(dut.flush_pend), 32'd0);
    apply(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("ar_first_rdy", 32'(atm_ready), 32'd1);
    tick();
    chk("ar_first_cnt", 32'(dct_count), 32'd1);
    chk("ar_first_buf", 32'(dct_buffer), 32'h2);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
      chk($sformatf("ar_no_frame%0d", i), 32'(frame_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nios_with_no_onchip_sdram_cpu_oci_dct_packer.md
NIOS_WITH_NO_ONCHIP_SDRAM_CPU_OCI_DCT_PACKER -- requirements
Module: nios_with_no_onchip_sdram_cpu_oci_dct_packer

Interface
REQ-001 Parameters: none. Atom width is fixed at 2 bits, buffer capacity at 15 atoms, and buffer width at 30 bits.
REQ-002 clk  input  1  Single clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  Reset: asynchronous assert, active-low.
REQ-004 trc_on  input  1  Trace enable. While low, no atom is accepted.
REQ-005 atm_valid  input  1  A 2-bit trace atom is offered.
REQ-006 atm_data  input  2  Trace atom value.
REQ-007 atm_ready  output  1  Atom accepted this cycle when atm_valid and atm_ready are both high; combinational.
REQ-008 flush  input  1  Single-cycle request to emit a partial buffer.
REQ-009 clr_ovf  input  1  Clears the overflow flag.
REQ-010 dct_buffer  output  30  Live packing buffer, registered.
REQ-011 dct_count  output  4  Live atom count, 0..15, registered.
REQ-012 frame_valid  output  1  Frame slot holds a frame.
REQ-013 frame_ready  input  1  Downstream consumes the frame when frame_valid and frame_ready are both high.
REQ-014 frame_data  output  30  Frame payload.
REQ-015 frame_count  output  4  Number of valid atoms in the frame, 1..15.
REQ-016 overflow  output  1  Sticky atom-drop flag.

Function
REQ-017 An accepted atom is written to dct_buffer[2n+1:2n], where n is the current dct_count, and dct_count increments by 1.
- Latency: the result is visible at the next edge.
REQ-018 Define the internal signals as follows:
- slot_free = !frame_valid | frame_ready
- flush_req = flush | flush_pend
- xfer = slot_free & ((dct_count==15) | (flush_req & dct_count!=0))
REQ-019 atm_ready = trc_on & (dct_count<15) & !xfer. A flush transfer cycle therefore accepts no atom.
REQ-020 On xfer, at the clock edge:
- frame_data <= dct_buffer
- frame_count <= dct_count
- frame_valid <= 1
- dct_buffer <= 0
- dct_count <= 0
- flush_pend <= 0
REQ-021 If a frame is consumed and xfer does not occur in the same cycle, frame_valid <= 0. Consumption and xfer in the same cycle keeps frame_valid high with the new frame; there is no bubble.
REQ-022 Frame slot state machine:
- EMPTY (frame_valid=0) -> FULL on xfer.
- FULL -> EMPTY on consume without xfer.
- FULL -> FULL on consume with xfer, or when no consume occurs.
REQ-023 Flush while dct_count==0 and no xfer: flush_pend <= 0 and no frame is generated.
REQ-024 Flush while dct_count!=0 but slot not free: flush_pend <= 1, held until xfer. Atoms are still accepted while dct_count<15 and are included in the eventual frame.
REQ-025 dct_count==15 with slot not free: the buffer holds and atm_ready=0 until the slot frees.
REQ-026 overflow <= 1 on any cycle with atm_valid & trc_on & !atm_ready. The flag is set only this way.
REQ-027 clr_ovf clears overflow; if set and clear coincide, set wins.
REQ-028 trc_on low:
- atoms are ignored and overflow is not set;
- the buffer is retained;
- flush and frame transfer still operate.
REQ-029 frame_data and frame_count are held stable while frame_valid=1 and frame_ready=0.
REQ-030 dct_count never exceeds 15, and there is no wrap. Unused upper buffer bits of a partial frame are 0.

Reset
REQ-031 While reset_n=0, the following outputs and state are 0:
- dct_buffer, dct_count
- frame_valid, frame_data, frame_count
- overflow, flush_pend
REQ-032 Reset asserted mid-fill or mid-frame discards all contents, with no frame emitted.
REQ-033 The first atom is accepted on the first edge after reset_n rises, given trc_on=1.

Verification
REQ-034 Stimulus: frame_ready=1, trc_on=1, 15 atoms with atm_data=i%4 for i=0..14. Required response: the edge after the 15th atom gives dct_count=15; on the following edge frame_valid=1, frame_count=15, frame_data=30'h24E4E4E4, dct_count=0.
REQ-035 Stimulus: atoms 01, 10, 11, then a flush pulse. Required response: frame_valid=1, frame_count=3, frame_data=30'h39; the flush-cycle atm_ready=0.
REQ-036 Stimulus: flush at dct_count=0. Required response: no frame_valid and flush_pend=0.
REQ-037 Stimulus: frame_ready=0 and 31 atoms offered continuously. Required response:
- The first frame is held.
- The buffer stops at 15 with atm_ready=0.
- overflow=1 from the 31st atom onward.
- Once frame_ready=1 for one cycle, the second frame transfers the same cycle the first is consumed.
- clr_ovf then clears overflow.
REQ-038 Stimulus: reset_n pulsed low at dct_count=7 with frame_valid=1. Required response: all outputs are 0 immediately (asynchronously) and no frame is emitted afterwards.
REQ-039 Stimulus: trc_on=0 with atm_valid=1 for 10 cycles. Required response: dct_count is unchanged and overflow stays 0.
